comparator_sequencer: RTL and testbench

- Clocked front-end/back-end controller for the power-gated multi-bit comparator.
- Accepts operand pairs over a valid/ready stream and holds them stable on the comparator inputs.
- Raises the comparator enable for a fixed settle window, registers the less/equal/greater result and presents it downstream over valid/ready.
- Drops the enable between operations so the comparator stays power-gated, and keeps saturating outcome statistics.

---
 rtl/comparator_sequencer.sv | 177 +++++++++++++++++
 tb/tb_comparator_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/comparator_sequencer.sv
// -----------------------------------------------------------------------------
// comparator_sequencer
//   Controls a power-gated multi-bit comparator. It takes one operand pair at a
//   time from a valid/ready stream and holds it on the comparator inputs. It
//   clears the comparator for one cycle, then enables it for SETTLE cycles and
//   registers the less/equal/greater flags. The result is offered downstream
//   over valid/ready, and the sequencer keeps saturating outcome statistics.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for an operand pair, in_ready=1, comparator gated off
//   LOAD  | operands latched, comparator held in reset for one cycle
//   EVAL  | comparator enabled, settle counter running down to 0
//   OUT   | result presented, waiting for out_ready
//
// Ports
//   clk, reset              : clock, asynchronous active-high reset
//   in_valid/in_ready       : operand stream handshake
//   a_in, b_in              : operands (N+1 bits)
//   cmp_enable, cmp_reset   : comparator power gate and clear
//   cmp_a, cmp_b            : registered operands to the comparator
//   cmp_less/equal/greater  : comparator result flags
//   out_valid/out_ready     : result stream handshake
//   out_less/equal/greater  : registered result flags
//   out_error               : sampled flags were not exactly one-hot
//   cnt_less/equal/greater  : saturating counts of accepted results
//   busy                    : high in every state except IDLE
// -----------------------------------------------------------------------------
module comparator_sequencer #(
    parameter int N      = 3,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       a_in,
    input  logic [N:0]       b_in,
    output logic             cmp_enable,
    output logic             cmp_reset,
    output logic [N:0]       cmp_a,
    output logic [N:0]       cmp_b,
    input  logic             cmp_less,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_less,
    output logic             out_equal,
    output logic             out_greater,
    output logic             out_error,
    output logic [CNT_W-1:0] cnt_less,
    output logic [CNT_W-1:0] cnt_equal,
    output logic [CNT_W-1:0] cnt_greater,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, LOAD, EVAL, OUT} state_t;

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [N:0]       cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    logic             en_q, en_d;
    logic             less_q, less_d, equal_q, equal_d, greater_q, greater_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cl_q, cl_d, ce_q, ce_d, cg_q, cg_d;
    logic             one_hot;

    // Exactly one of three flags: odd parity rules out two, the AND rules out three.
    assign one_hot = (cmp_less ^ cmp_equal ^ cmp_greater) &
                     ~(cmp_less & cmp_equal & cmp_greater);

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cmp_a_d   = cmp_a_q;
        cmp_b_d   = cmp_b_q;
        en_d      = en_q;
        less_d    = less_q;
        equal_d   = equal_q;
        greater_d = greater_q;
        err_d     = err_q;
        cl_d      = cl_q;
        ce_d      = ce_q;
        cg_d      = cg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cmp_a_d = a_in;
                    cmp_b_d = b_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                settle_d = SETTLE_LOAD;
                en_d     = 1'b1;
                state_d  = EVAL;
            end
            EVAL: begin
                if (settle_q == 8'd0) begin
                    less_d    = cmp_less;
                    equal_d   = cmp_equal;
                    greater_d = cmp_greater;
                    err_d     = ~one_hot;
                    en_d      = 1'b0;
                    state_d   = OUT;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    // A malformed result is still delivered but not counted.
                    if (!err_q) begin
                        if (less_q && cl_q != CNT_MAX)    cl_d = cl_q + CNT_ONE;
                        if (equal_q && ce_q != CNT_MAX)   ce_d = ce_q + CNT_ONE;
                        if (greater_q && cg_q != CNT_MAX) cg_d = cg_q + CNT_ONE;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            cmp_a_q   <= '0;
            cmp_b_q   <= '0;
            en_q      <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
            err_q     <= 1'b0;
            cl_q      <= '0;
            ce_q      <= '0;
            cg_q      <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            cmp_a_q   <= cmp_a_d;
            cmp_b_q   <= cmp_b_d;
            en_q      <= en_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            greater_q <= greater_d;
            err_q     <= err_d;
            cl_q      <= cl_d;
            ce_q      <= ce_d;
            cg_q      <= cg_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == OUT);
    // Comparator stays cleared for the whole reset, not just after the next edge.
    assign cmp_reset   = reset | (state_q == LOAD);
    assign cmp_enable  = en_q;
    assign cmp_a       = cmp_a_q;
    assign cmp_b       = cmp_b_q;
    assign out_less    = less_q;
    assign out_equal   = equal_q;
    assign out_greater = greater_q;
    assign out_error   = err_q;
    assign cnt_less    = cl_q;
    assign cnt_equal   = ce_q;
    assign cnt_greater = cg_q;

endmodule

// File: tb/tb_comparator_sequencer.sv
module tb_comparator_sequencer;

    localparam int SETTLE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, out_ready;
    logic [3:0] a_in, b_in;
    logic       force_bad;

    logic       in_ready, cmp_enable, cmp_reset, out_valid, busy;
    logic [3:0] cmp_a, cmp_b;
    logic       cmp_less, cmp_equal, cmp_greater;
    logic       out_less, out_equal, out_greater, out_error;
    logic [7:0] cnt_less, cnt_equal, cnt_greater;

    logic       in_ready2, cmp_enable2, cmp_reset2, out_valid2, busy2;
    logic [3:0] cmp_a2, cmp_b2;
    logic       cmp_less2, cmp_equal2, cmp_greater2;
    logic       out_less2, out_equal2, out_greater2, out_error2;
    logic [1:0] cnt_less2, cnt_equal2, cnt_greater2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int exp_l = 0, exp_e = 0, exp_g = 0;
    int exp_l2 = 0, exp_e2 = 0, exp_g2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural comparator: outputs 0 while gated off, optional illegal result.
    always_comb begin
        cmp_less = 1'b0; cmp_equal = 1'b0; cmp_greater = 1'b0;
        if (cmp_enable && !cmp_reset) begin
            if (force_bad) begin
                cmp_less = 1'b1; cmp_greater = 1'b1;
            end else begin
                cmp_less    = (cmp_a < cmp_b);
                cmp_equal   = (cmp_a == cmp_b);
                cmp_greater = (cmp_a > cmp_b);
            end
        end
    end

    always_comb begin
        cmp_less2 = 1'b0; cmp_equal2 = 1'b0; cmp_greater2 = 1'b0;
        if (cmp_enable2 && !cmp_reset2) begin
            if (force_bad) begin
                cmp_less2 = 1'b1; cmp_greater2 = 1'b1;
            end else begin
                cmp_less2    = (cmp_a2 < cmp_b2);
                cmp_equal2   = (cmp_a2 == cmp_b2);
                cmp_greater2 = (cmp_a2 > cmp_b2);
            end
        end
    end

    comparator_sequencer #(.N(3), .SETTLE(SETTLE), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cmp_enable(cmp_enable), .cmp_reset(cmp_reset),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_less(cmp_less), .cmp_equal(cmp_equal),
        .cmp_greater(cmp_greater), .out_valid(out_valid), .out_ready(out_ready),
        .out_less(out_less), .out_equal(out_equal), .out_greater(out_greater),
        .out_error(out_error), .cnt_less(cnt_less), .cnt_equal(cnt_equal),
        .cnt_greater(cnt_greater), .busy(busy)
    );

    // Narrow-counter instance running in lockstep to exercise saturation.
    comparator_sequencer #(.N(3), .SETTLE(SETTLE), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .a_in(a_in), .b_in(b_in), .cmp_enable(cmp_enable2), .cmp_reset(cmp_reset2),
        .cmp_a(cmp_a2), .cmp_b(cmp_b2), .cmp_less(cmp_less2), .cmp_equal(cmp_equal2),
        .cmp_greater(cmp_greater2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_less(out_less2), .out_equal(out_equal2), .out_greater(out_greater2),
        .out_error(out_error2), .cnt_less(cnt_less2), .cnt_equal(cnt_equal2),
        .cnt_greater(cnt_greater2), .busy(busy2)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         hold;
        bit         bad;
        bit         gap;
        logic       l, e, g, err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_cnt_l"}, 32'(cnt_less), 32'(exp_l));
        chk({name, "_cnt_e"}, 32'(cnt_equal), 32'(exp_e));
        chk({name, "_cnt_g"}, 32'(cnt_greater), 32'(exp_g));
        chk({name, "_cnt2"}, {26'd0, cnt_less2, cnt_equal2, cnt_greater2},
            32'((exp_l2 << 4) | (exp_e2 << 2) | exp_g2));
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input vec_t v);
        int n;
        int en;
        force_bad = v.bad;
        a_in = v.a; b_in = v.b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_wait", 32'(n < 50), 32'd1);
        if (v.gap) chk("spacing", 32'(cyc - last_acc), 32'(SETTLE + 3));
        last_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        a_in = ~v.a; b_in = ~v.b;
        chk("load_state", {29'd0, busy, in_ready, cmp_reset}, 32'b101);
        n = 0; en = 0;
        while (!out_valid && n < 50) begin
            if (cmp_enable) en++;
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(SETTLE + 1));
        chk("enable_cycles", 32'(en), 32'(SETTLE));
        chk("out_gate", {30'd0, cmp_enable, in_ready}, 32'd0);
        chk("flags", {28'd0, out_less, out_equal, out_greater, out_error},
            {28'd0, v.l, v.e, v.g, v.err});
        chk("operand_hold", {24'd0, cmp_a, cmp_b}, {24'd0, v.a, v.b});
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("stall", {26'd0, out_valid, in_ready, out_less, out_equal, out_greater, out_error},
                {26'd0, 1'b1, 1'b0, v.l, v.e, v.g, v.err});
            chk_counts("stall");
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (!v.err) begin
            if (v.l) begin if (exp_l < 255) exp_l++; if (exp_l2 < 3) exp_l2++; end
            if (v.e) begin if (exp_e < 255) exp_e++; if (exp_e2 < 3) exp_e2++; end
            if (v.g) begin if (exp_g < 255) exp_g++; if (exp_g2 < 3) exp_g2++; end
        end
        chk_counts("done");
        chk("back_idle", {30'd0, in_ready, out_valid}, 32'b10);
        force_bad = 1'b0;
    endtask

    initial begin
        //            a      b      hold bad gap  l     e     g     err
        vecs[0]  = '{4'hA, 4'h5, 0,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'h3, 4'h3, 0,  0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'h2, 4'h9, 0,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'hF, 4'h0, 0,  0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'h7, 4'h7, 10, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'h4, 4'h4, 0,  1, 0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{4'h1, 4'h2, 0,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'h0, 4'h1, 0,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'h1, 4'h5, 0,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'h2, 4'h3, 0,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'h0, 4'hF, 0,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'hE, 4'hF, 0,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = 4'h0; b_in = 4'h0; force_bad = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {28'd0, cmp_enable, cmp_reset, out_valid, busy}, 32'b0100);
        chk("rst_out", {28'd0, out_less, out_equal, out_greater, out_error}, 32'd0);
        chk_counts("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {29'd0, in_ready, busy, cmp_reset}, 32'b100);

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Reset in the middle of an evaluation.
        a_in = 4'h6; b_in = 4'h6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_eval_en", 32'(cmp_enable), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_ctrl", {27'd0, cmp_enable, cmp_reset, out_valid, busy, cmp_enable2}, 32'b01000);
        chk("async_out", {28'd0, out_less, out_equal, out_greater, out_error}, 32'd0);
        chk("async_cmp", {24'd0, cmp_a, cmp_b}, 32'd0);
        exp_l = 0; exp_e = 0; exp_g = 0; exp_l2 = 0; exp_e2 = 0; exp_g2 = 0;
        chk_counts("async");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 6; i < 12; i++) run_op(vecs[i]);
        chk("sat_narrow", 32'(cnt_less2), 32'd3);
        chk("wide_less", 32'(cnt_less), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
